// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory wait controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    WPOST  = 2'd3
  } dmem_state_t;

  // Returned as load data when the watchdog aborts a read.
  localparam logic [31:0] DMEM_ERR_PAT = 32'hDEADBEEF;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Access-cycle counter; expired pulses on the TIMEOUT-th counted cycle.
// TIMEOUT=0 removes the counter and ties expired low.
module dmem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst, clr, en};
      assign expired   = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                              cnt <= '0;
        else if (clr)                         cnt <= '0;
        else if (en && cnt != CW'(TIMEOUT))   cnt <= cnt + CW'(1);
      end

      // This cycle brings the count to TIMEOUT.
      assign expired = en && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/dmem_wait_ctrl.sv
// MEM-stage data-memory req/ack controller with pipeline stall output.
// Optional posted stores: define DMEM_POSTED_WRITE_EN.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          pipe_en,
  input  logic                          MemRead,
  input  logic                          MemWrite,
  input  logic [ADDR_W-1:0]             Address,
  input  logic [DATA_W-1:0]             WriteData,
  input  logic [be_width(DATA_W)-1:0]   ByteEn,
  output logic [DATA_W-1:0]             ReadData,
  output logic                          dmem_wait,
  output logic                          dmem_err,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [be_width(DATA_W)-1:0]   mem_be,
  input  logic                          mem_ack,
  input  logic [DATA_W-1:0]             mem_rdata
);
  dmem_state_t state;
  logic        req_any, accept, wait_idle, wd_exp;

  assign req_any = MemRead | MemWrite;

`ifdef DMEM_POSTED_WRITE_EN
  // A store is only taken when the pipeline advances past it; otherwise it
  // stays presented and is picked up on a later cycle without stalling.
  logic post;
  assign post      = MemWrite & pipe_en;
  assign accept    = enable & (MemWrite ? pipe_en : MemRead);
  assign wait_idle = enable & MemRead & ~MemWrite;
`else
  assign accept    = enable & req_any;
  assign wait_idle = accept;
`endif

  always_comb begin
    dmem_wait = 1'b0;
    case (state)
      IDLE:    dmem_wait = wait_idle;
      ACCESS:  dmem_wait = 1'b1;
      WPOST:   dmem_wait = req_any;
      default: dmem_wait = 1'b0;
    endcase
    if (rst) dmem_wait = 1'b0;
  end

  dmem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == IDLE),
    .en      ((state == ACCESS) || (state == WPOST)),
    .expired (wd_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ReadData  <= '0;
      dmem_err  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mem_req   <= 1'b1;
          mem_we    <= MemWrite;
          mem_addr  <= Address;
          mem_wdata <= WriteData;
          mem_be    <= MemWrite ? ByteEn : '1;
`ifdef DMEM_POSTED_WRITE_EN
          state     <= post ? WPOST : ACCESS;
`else
          state     <= ACCESS;
`endif
        end
        ACCESS: begin
          // An ack on the last allowed cycle beats the watchdog.
          if (mem_ack) begin
            if (!mem_we) ReadData <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (wd_exp) begin
            if (!mem_we) ReadData <= DATA_W'(DMEM_ERR_PAT);
            mem_req  <= 1'b0;
            dmem_err <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: if (pipe_en) state <= IDLE;
`ifdef DMEM_POSTED_WRITE_EN
        WPOST: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (wd_exp) begin
            mem_req  <= 1'b0;
            dmem_err <= 1'b1;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: vector table plus directed multi-cycle sequences,
// with a bus responder that pops expected transactions from a queue.
module tb_dmem_wait_ctrl;
  localparam int AW = 32, DW = 32, BW = 4, TO = 8;

  logic          clk = 1'b0;
  logic          rst, enable, pipe_en, MemRead, MemWrite;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [BW-1:0] ByteEn;
  logic [DW-1:0] ReadData;
  logic          dmem_wait, dmem_err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_wait_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pipe_en(pipe_en),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ByteEn(ByteEn), .ReadData(ReadData),
    .dmem_wait(dmem_wait), .dmem_err(dmem_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          dly;    // ack in this ACCESS cycle; 0 = never
    logic [31:0] rdata;  // returned when the model has no entry
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic        force_ack = 1'b0;
  logic [31:0] force_rdata = '0;

  // Bus responder and scoreboard: one expected record per mem_req burst.
  bus_t cur;
  int   ack_cnt = 0;
  logic busy = 1'b0;
  always @(negedge clk) begin : resp
    logic ack_now;
    logic [31:0] w;
    ack_now = 1'b0;
    if (mem_req && !rst) begin
      if (!busy) begin
        busy = 1'b1;
        ack_cnt = 0;
        chk("bus_expected_req", 32'(bus_q.size() != 0), 32'd1);
        if (bus_q.size() != 0) cur = bus_q.pop_front();
        else cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, dly: 1, rdata: 32'h0};
        chk("bus_we", 32'(mem_we), 32'(cur.we));
        chk("bus_addr", mem_addr, cur.addr);
        chk("bus_be", 32'(mem_be), 32'(cur.be));
        if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
      end
      ack_cnt++;
      if (cur.dly != 0 && ack_cnt == cur.dly) begin
        ack_now = 1'b1;
        if (cur.we) begin
          w = mem_m.exists(cur.addr) ? mem_m[cur.addr] : 32'h0;
          for (int b = 0; b < 4; b++) if (cur.be[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
          mem_m[cur.addr] = w;
        end else begin
          mem_rdata = mem_m.exists(cur.addr) ? mem_m[cur.addr] : cur.rdata;
        end
      end
    end else begin
      busy = 1'b0;
    end
    if (force_ack) mem_rdata = force_rdata;
    mem_ack = ack_now | force_ack;
  end

  // Present a request (called just after a rising edge) and queue its bus record.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input int dly,
                       input logic [31:0] rdat);
    bus_t b;
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd; ByteEn = be;
    pipe_en = 1'b0;
    b.we = wr; b.addr = a; b.wdata = wd; b.be = wr ? be : 4'hF; b.dly = dly; b.rdata = rdat;
    bus_q.push_back(b);
  endtask

  // Count stalled cycles until dmem_wait drops; returns at that falling edge.
  task automatic wait_done(output int nw, output int nreq);
    logic done;
    nw = 0; nreq = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (!dmem_wait) done = 1'b1;
      else nw++;
    end
    if (!done) chk("wait_done_bound", 32'(dmem_wait), 32'd0);
  endtask

  task automatic release_pipe();
    pipe_en = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          dly;
    logic [31:0] rdata;
    int          exp_wait;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int nw, nreq;
    rst = 1'b1; enable = 1'b1; pipe_en = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    Address = 32'h0; WriteData = 32'h0; ByteEn = 4'h0;

    // Reset state, with a request presented.
    #3;
    chk("rst_dmem_wait", 32'(dmem_wait), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_read_data", ReadData, 32'h0);
    chk("rst_dmem_err", 32'(dmem_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    MemRead = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 3, 32'h12345678, 4, 32'h12345678});
`ifndef DMEM_POSTED_WRITE_EN
    vecs.push_back(vec_t'{1'b0, 1'b1, 32'h204, 32'hA5A5A5A5, 4'b0011, 1, 32'h0, 2, 32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 2, 32'hEEEEEEEE, 3, 32'h0000A5A5});
    vecs.push_back(vec_t'{1'b1, 1'b1, 32'h40, 32'h11223344, 4'b1100, 2, 32'h0, 3, 32'h0000A5A5});
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1, 32'hEEEEEEEE, 2, 32'h11220000});
`endif
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 8, 32'h0BADCAFE, 9, 32'h0BADCAFE});

    foreach (vecs[i]) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
            vecs[i].dly, vecs[i].rdata);
      wait_done(nw, nreq);
      chk($sformatf("v%0d_wait_cycles", i), 32'(nw), 32'(vecs[i].exp_wait));
      chk($sformatf("v%0d_req_cycles", i), 32'(nreq), 32'(vecs[i].dly));
      chk($sformatf("v%0d_read_data", i), ReadData, vecs[i].exp_rd);
      chk($sformatf("v%0d_dmem_err", i), 32'(dmem_err), 32'd0);
      release_pipe();
    end

    // DONE held by pipe_en=0: no re-issue, data stable, then IDLE on release.
    issue(1'b1, 1'b0, 32'h120, 32'h0, 4'h0, 1, 32'h55AA55AA);
    wait_done(nw, nreq);
    chk("hold_wait_cycles", 32'(nw), 32'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_dmem_wait", 32'(dmem_wait), 32'd0);
      chk("hold_mem_req", 32'(mem_req), 32'd0);
      chk("hold_read_data", ReadData, 32'h55AA55AA);
    end
    release_pipe();
    issue(1'b1, 1'b0, 32'h124, 32'h0, 4'h0, 1, 32'h13579BDF);
    @(negedge clk);
    chk("after_hold_idle_wait", 32'(dmem_wait), 32'd1);
    wait_done(nw, nreq);
    chk("after_hold_wait_cycles", 32'(nw), 32'd1);
    chk("after_hold_read_data", ReadData, 32'h13579BDF);
    release_pipe();

    // Watchdog expiry on a read, then sticky error across a good access.
    issue(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 0, 32'h0);
    wait_done(nw, nreq);
    chk("to_req_cycles", 32'(nreq), 32'd8);
    chk("to_wait_cycles", 32'(nw), 32'd9);
    chk("to_dmem_err", 32'(dmem_err), 32'd1);
    chk("to_read_data", ReadData, 32'hDEADBEEF);
    release_pipe();
    issue(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 2, 32'h0F0F0F0F);
    wait_done(nw, nreq);
    chk("post_to_wait_cycles", 32'(nw), 32'd3);
    chk("post_to_read_data", ReadData, 32'h0F0F0F0F);
    chk("post_to_err_sticky", 32'(dmem_err), 32'd1);
    release_pipe();

    // enable=0 blocks acceptance; dropping it mid-access does not abort.
    enable = 1'b0; MemRead = 1'b1; Address = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("dis_dmem_wait", 32'(dmem_wait), 32'd0);
      chk("dis_mem_req", 32'(mem_req), 32'd0);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    issue(1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 4, 32'h77777777);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_done(nw, nreq);
    chk("en_drop_wait_cycles", 32'(nw), 32'd3);
    chk("en_drop_read_data", ReadData, 32'h77777777);
    enable = 1'b1;
    release_pipe();

    // Asynchronous reset in the middle of an access.
    issue(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 0, 32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_dmem_wait", 32'(dmem_wait), 32'd0);
    chk("arst_read_data", ReadData, 32'h0);
    chk("arst_dmem_err", 32'(dmem_err), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    MemRead = 1'b0; pipe_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    force_rdata = 32'hFFFFFFFF; force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_read_data", ReadData, 32'h0);
    chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
    chk("stray_ack_dmem_wait", 32'(dmem_wait), 32'd0);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h604, 32'h0, 4'h0, 2, 32'hC0FFEE00);
    wait_done(nw, nreq);
    chk("post_rst_wait_cycles", 32'(nw), 32'd3);
    chk("post_rst_read_data", ReadData, 32'hC0FFEE00);
    release_pipe();

`ifdef DMEM_POSTED_WRITE_EN
    // Store held by pipe_en=0 is not posted; once taken it does not stall,
    // and the following load waits for the write to drain.
    begin
      bus_t b;
      MemWrite = 1'b1; MemRead = 1'b0; Address = 32'h10;
      WriteData = 32'h600DF00D; ByteEn = 4'hF; pipe_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk("post_held_wait", 32'(dmem_wait), 32'd0);
        chk("post_held_mem_req", 32'(mem_req), 32'd0);
      end
      b.we = 1'b1; b.addr = 32'h10; b.wdata = 32'h600DF00D; b.be = 4'hF; b.dly = 4; b.rdata = 32'h0;
      bus_q.push_back(b);
      pipe_en = 1'b1;
      #1;
      chk("post_store_wait", 32'(dmem_wait), 32'd0);
      @(posedge clk); #1;
      chk("post_store_issued", 32'(mem_req), 32'd1);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hEEEEEEEE);
      wait_done(nw, nreq);
      chk("post_load_wait_cycles", 32'(nw), 32'd6);
      chk("post_load_req_cycles", 32'(nreq), 32'd5);
      chk("post_load_read_data", ReadData, 32'h600DF00D);
      release_pipe();
    end
`endif

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Data-memory side of the MEM-stage stall handshake.
- Takes the pipeline's MEM-stage load/store request and runs it as a req/ack transaction on a multi-cycle data memory bus.
- Drives dmem_wait to the hazard unit so the pipeline freezes until the access completes.
- Returns load data held stable for capture into MEM/WB.

Parameters:
ADDR_W, 32, address width of pipeline and bus side
DATA_W, 32, data width; byte enables are DATA_W/8 bits
TIMEOUT, 255, max ACCESS cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  global enable; when 0, no new access is accepted
pipe_en  in  1  pipeline advance strobe from the hazard unit
MemRead  in  1  MEM-stage load request
MemWrite  in  1  MEM-stage store request
Address  in  ADDR_W  MEM-stage byte address
WriteData  in  DATA_W  store data
ByteEn  in  DATA_W/8  store byte enables
ReadData  out  DATA_W  load result, valid in DONE
dmem_wait  out  1  stall request to the hazard unit
dmem_err  out  1  sticky watchdog error flag
mem_req  out  1  bus request
mem_we  out  1  bus write strobe
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_be  out  DATA_W/8  bus byte enables (all ones for reads)
mem_ack  in  1  bus completion, single-cycle pulse
mem_rdata  in  DATA_W  bus read data, valid with mem_ack

Behaviour:
- Reset (async, immediate): state=IDLE; all registered outputs 0 (ReadData, mem_req, mem_we, mem_addr, mem_wdata, mem_be, dmem_err, cycle counter).
- dmem_wait is combinational: 1 when (IDLE and enable and (MemRead or MemWrite)), or when in ACCESS; 0 otherwise. It is 0 during reset.
- IDLE, with enable=1 and a request present:
  - Register Address, WriteData, ByteEn and we=MemWrite into the bus outputs.
  - mem_req=1 from the next cycle; go to ACCESS; clear the counter.
  - If MemRead and MemWrite are both 1, the write wins.
- ACCESS:
  - Bus outputs stay stable; counter increments each cycle.
  - On mem_ack: if a read, ReadData<=mem_rdata; mem_req<=0; go to DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without ack: mem_req<=0; dmem_err<=1 (sticky until rst); ReadData<=32'hDEADBEEF for reads; go to DONE.
  - enable falling during ACCESS does not abort; the access completes.
- DONE:
  - dmem_wait=0 and ReadData holds.
  - pipe_en=1: go to IDLE.
  - pipe_en=0 (e.g. imem_wait stall): remain in DONE. The same request is never re-issued.
- Latency: a read acked k cycles after mem_req rises gives dmem_wait high for k+1 cycles. Minimum k=1, i.e. wait high 2 cycles.
- mem_ack outside ACCESS is ignored.
- Exactly one outstanding bus transaction at a time.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN
- Defined:
  - A store seen in IDLE with pipe_en=1 is latched and issued; the FSM goes to WPOST with dmem_wait=0, so the pipeline continues.
  - In WPOST, any new MemRead/MemWrite raises dmem_wait until the posted write acks. The FSM then returns to IDLE and the new request starts normally, which preserves ordering.
  - A store seen with pipe_en=0 is not posted; it is retried while presented.
  - A watchdog expiry in WPOST sets dmem_err and returns to IDLE.
- Undefined: WPOST does not exist; stores stall like loads.

Decomposition:
- Shared package/include dmem_pkg:
  - State encoding: IDLE, ACCESS, DONE, WPOST.
  - Error pattern constant 32'hDEADBEEF.
  - Byte-enable width function DATA_W/8.
- One sub-module: dmem_watchdog. It holds the cycle counter sized $clog2(TIMEOUT+1), with clear/enable inputs and an expired output. It is tied off when TIMEOUT=0.

Test Plan:
- Load: MemRead, Address=0x100; ack 3 cycles after mem_req with rdata=0x12345678 -> dmem_wait high 4 cycles, one mem_req burst, mem_be=4'hF, ReadData=0x12345678 in DONE.
- Store: MemWrite, Address=0x204, WriteData=0xA5A5A5A5, ByteEn=4'b0011, ack on first ACCESS cycle -> mem_we=1, mem_be=4'b0011, dmem_wait high 2 cycles, ReadData unchanged.
- DONE with pipe_en=0 for 2 cycles -> dmem_wait=0, mem_req stays 0, ReadData stable; IDLE on the first pipe_en=1.
- TIMEOUT=8, no ack -> mem_req high exactly 8 cycles, then dmem_err=1, ReadData=0xDEADBEEF, dmem_wait drops; dmem_err stays 1 across later accesses.
- rst pulsed mid-ACCESS -> mem_req and outputs go to 0 without waiting for a clock edge; a later ack is ignored; next request starts cleanly.
- With DMEM_POSTED_WRITE_EN: store to 0x10 then load from 0x10 the next cycle, write ack after 4 cycles -> dmem_wait low for the store cycle, high for the load until the write acks, then the load is issued; read returns the written value.
